hex_display_scan: RTL and testbench

//  Parametrised, time-multiplexed multi-digit hex display driver for common-anode 7-seg banks.

---
 rtl/hex_display_scan.sv | 191 +++++++++++++++++++
 tb/tb_hex_display_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver for common-anode 7-segment banks.
// A load strobe captures a new value into a shadow register. The shadow moves
// into the displayed value only when the scan wraps, so a frame never shows a
// mix of old and new digits. All outputs are registered.
module hex_display_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    load_pend,
   output logic                    frame_tick
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
   localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_INV}};

   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic [DIG_W-1:0]        dig_idx_q, dig_idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic                    load_pend_q, load_pend_d;
   logic                    frame_tick_q, frame_tick_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    div_term;
   logic                    wrap;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    lz_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   onehot;
   logic [6:0]              lit;

   // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0: seg_decode = 7'h3F;
         4'h1: seg_decode = 7'h06;
         4'h2: seg_decode = 7'h5B;
         4'h3: seg_decode = 7'h4F;
         4'h4: seg_decode = 7'h66;
         4'h5: seg_decode = 7'h6D;
         4'h6: seg_decode = 7'h7D;
         4'h7: seg_decode = 7'h07;
         4'h8: seg_decode = 7'h7F;
         4'h9: seg_decode = 7'h6F;
         4'hA: seg_decode = 7'h77;
         4'hB: seg_decode = 7'h7C;
         4'hC: seg_decode = 7'h39;
         4'hD: seg_decode = 7'h5E;
         4'hE: seg_decode = 7'h79;
         default: seg_decode = 7'h71;
      endcase
   endfunction

   // Refresh divider and digit pointer; both parked at 0 while disabled.
   always_comb begin
      div_term     = (div_cnt_q == DIV_LAST);
      wrap         = enable && div_term && (dig_idx_q == DIG_LAST);
      div_cnt_d    = div_cnt_q;
      dig_idx_d    = dig_idx_q;
      frame_tick_d = wrap;
      if (!enable) begin
         div_cnt_d = '0;
         dig_idx_d = '0;
      end else if (div_term) begin
         div_cnt_d = '0;
         dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // Shadow capture and tear-free transfer to the displayed value at wrap.
   // A load landing on the wrap cycle bypasses the shadow and shows at once.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      load_pend_d  = load_pend_q;
      if (wrap) begin
         if (load) begin
            disp_val_d = value_in;
            disp_dp_d  = dp_in;
         end else if (load_pend_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
         load_pend_d = 1'b0;
      end else if (load) begin
         shadow_val_d = value_in;
         shadow_dp_d  = dp_in;
         load_pend_d  = 1'b1;
      end
   end

   // Leading-zero mask: walk down from the top digit while every digit seen is zero.
   always_comb begin
      blank  = '0;
      lz_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run   = lz_run && (disp_val_q[4*i +: 4] == 4'h0);
         blank[i] = blank_lz && lz_run && (i != 0);
      end
   end

   // Select the current digit and form the next registered seg/dp/an values.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_idx_q == DIG_W'(i)) begin
            cur_nib   = disp_val_q[4*i +: 4];
            cur_dp    = disp_dp_q[i];
            cur_blank = blank[i];
            onehot[i] = 1'b1;
         end
      end
      lit = cur_blank ? 7'h00 : seg_decode(cur_nib);
      if (enable) begin
         seg_d = lit ^ SEG_OFF;
         dp_d  = cur_dp ^ SEG_INV;
         an_d  = onehot ^ AN_OFF;
      end else begin
         seg_d = SEG_OFF;
         dp_d  = SEG_INV;
         an_d  = AN_OFF;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         dig_idx_q    <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         load_pend_q  <= 1'b0;
         frame_tick_q <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= SEG_INV;
         an_q         <= AN_OFF;
      end else begin
         div_cnt_q    <= div_cnt_d;
         dig_idx_q    <= dig_idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         load_pend_q  <= load_pend_d;
         frame_tick_q <= frame_tick_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign load_pend  = load_pend_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan with 4 digits, 4-cycle dwell, active-low seg and anode.
module tb_hex_display_scan;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        load_pend;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   hex_display_scan #(
      .NUM_DIGITS(4),
      .REFRESH_DIV(4),
      .SEG_ACTIVE_LOW(1),
      .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .load(load),
      .value_in(value_in),
      .dp_in(dp_in),
      .blank_lz(blank_lz),
      .seg(seg),
      .dp(dp),
      .an(an),
      .load_pend(load_pend),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpv;
      logic        blz;
      logic [27:0] es;   // expected seg {d3,d2,d1,d0}
      logic [3:0]  ed;   // expected dp pin per digit (active low)
   } vec_t;

   vec_t       vecs [8];
   logic [3:0] an_tab [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns at the negedge where frame_tick is high.
   task automatic wait_tick(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (frame_tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: frame_tick got none expected pulse within 40 cycles", name);
      end
   endtask

   // Called at the frame_tick negedge; samples each digit once, ends inside digit 3.
   task automatic check_frame(input string name, input logic [27:0] es, input logic [3:0] ed);
      @(negedge clk);
      chk({name, " tick_width"}, frame_tick, 1'b0);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) repeat (4) @(negedge clk);
         chk($sformatf("%s an%0d", name, d), an, an_tab[d]);
         chk($sformatf("%s seg%0d", name, d), seg, es[7*d +: 7]);
         chk($sformatf("%s dp%0d", name, d), dp, ed[d]);
      end
   endtask

   initial begin
      logic [6:0] prev_seg;

      an_tab[0] = 4'b1110;
      an_tab[1] = 4'b1101;
      an_tab[2] = 4'b1011;
      an_tab[3] = 4'b0111;

      vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
      vecs[3] = '{16'h0050, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1011};
      vecs[4] = '{16'h0300, 4'b0000, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b1111};
      vecs[5] = '{16'h9876, 4'b0001, 1'b1, {7'h10, 7'h00, 7'h78, 7'h02}, 4'b1110};
      vecs[6] = '{16'hC0D0, 4'b1000, 1'b0, {7'h46, 7'h40, 7'h21, 7'h40}, 4'b0111};
      vecs[7] = '{16'h0000, 4'b1111, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000};

      rst_n    = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      value_in = 16'h0;
      dp_in    = 4'h0;
      blank_lz = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst seg", seg, 7'h7F);
      chk("rst dp", dp, 1'b1);
      chk("rst an", an, 4'b1111);
      chk("rst load_pend", load_pend, 1'b0);
      chk("rst frame_tick", frame_tick, 1'b0);

      // First scan after reset: digit 0 lit for exactly 4 cycles, value 0.
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("start an", an, 4'b1110);
      chk("start seg", seg, 7'h40);
      repeat (3) @(negedge clk);
      chk("start an dwell", an, 4'b1110);
      @(negedge clk);
      chk("start an next", an, 4'b1101);
      wait_tick("start");
      check_frame("zero", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

      // Table: load mid-frame, confirm pending, then check the next frame.
      for (int v = 0; v < 8; v++) begin
         prev_seg = seg;
         value_in = vecs[v].val;
         dp_in    = vecs[v].dpv;
         load     = 1'b1;
         @(negedge clk);
         load = 1'b0;
         chk($sformatf("v%0d pend", v), load_pend, 1'b1);
         chk($sformatf("v%0d hold", v), seg, prev_seg);
         blank_lz = vecs[v].blz;
         wait_tick($sformatf("v%0d tick", v));
         chk($sformatf("v%0d pend_clr", v), load_pend, 1'b0);
         check_frame($sformatf("v%0d", v), vecs[v].es, vecs[v].ed);
      end

      // Load exactly on the wrap cycle: applied immediately, never pending.
      blank_lz = 1'b1;
      value_in = 16'hBEEF;
      dp_in    = 4'b0000;
      repeat (2) @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("wrapld tick", frame_tick, 1'b1);
      chk("wrapld pend", load_pend, 1'b0);
      check_frame("wrapld", {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

      // Disable mid-scan, load while dark, re-enable at digit 0.
      enable = 1'b0;
      @(negedge clk);
      chk("dis an", an, 4'b1111);
      chk("dis seg", seg, 7'h7F);
      chk("dis dp", dp, 1'b1);
      chk("dis tick", frame_tick, 1'b0);
      value_in = 16'h0300;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("dis pend", load_pend, 1'b1);
      repeat (3) @(negedge clk);
      chk("dis an hold", an, 4'b1111);
      chk("dis tick hold", frame_tick, 1'b0);
      enable = 1'b1;
      @(negedge clk);
      chk("reen an", an, 4'b1110);
      chk("reen seg", seg, 7'h0E);
      repeat (3) @(negedge clk);
      chk("reen an dwell", an, 4'b1110);
      @(negedge clk);
      chk("reen an next", an, 4'b1101);
      chk("reen pend", load_pend, 1'b1);
      wait_tick("reen");
      chk("reen pend_clr", load_pend, 1'b0);
      check_frame("reen", {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b1111);

      // Reset while a load is pending: pending value discarded.
      value_in = 16'h12AF;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("rst2 pend_pre", load_pend, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2 an", an, 4'b1111);
      chk("rst2 seg", seg, 7'h7F);
      chk("rst2 dp", dp, 1'b1);
      chk("rst2 pend", load_pend, 1'b0);
      chk("rst2 tick", frame_tick, 1'b0);
      rst_n    = 1'b1;
      blank_lz = 1'b0;
      @(negedge clk);
      chk("rst2 an0", an, 4'b1110);
      chk("rst2 seg0", seg, 7'h40);
      wait_tick("rst2");
      chk("rst2 pend_after", load_pend, 1'b0);
      check_frame("rst2", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
